keypad_matrix_emulator: RTL



---
 rtl/keypad_pkg.sv | 55 +++++
 rtl/contact_bounce_gen.sv | 67 ++++++
 rtl/keypad_matrix_emulator.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - keypad code constants, code-to-matrix mapping and emulator FSM states
package keypad_pkg;

    localparam logic [3:0] KEY_0   = 4'h0;
    localparam logic [3:0] KEY_1   = 4'h1;
    localparam logic [3:0] KEY_2   = 4'h2;
    localparam logic [3:0] KEY_3   = 4'h3;
    localparam logic [3:0] KEY_4   = 4'h4;
    localparam logic [3:0] KEY_5   = 4'h5;
    localparam logic [3:0] KEY_6   = 4'h6;
    localparam logic [3:0] KEY_7   = 4'h7;
    localparam logic [3:0] KEY_8   = 4'h8;
    localparam logic [3:0] KEY_9   = 4'h9;
    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_CLR = 4'hE;
    localparam logic [3:0] KEY_EQ  = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_BOUNCE,
        ST_HOLD,
        ST_RELEASE_BOUNCE,
        ST_GAP
    } kp_state_t;

    // Returns {col[1:0], row[1:0]}; col indexes COLS, row indexes ROWS.
    function automatic logic [3:0] key_to_colrow(input logic [3:0] code);
        logic [3:0] cr;
        cr = 4'h0;
        case (code)
            KEY_1:   cr = {2'd0, 2'd0};
            KEY_4:   cr = {2'd0, 2'd1};
            KEY_7:   cr = {2'd0, 2'd2};
            KEY_CLR: cr = {2'd0, 2'd3};
            KEY_2:   cr = {2'd1, 2'd0};
            KEY_5:   cr = {2'd1, 2'd1};
            KEY_8:   cr = {2'd1, 2'd2};
            KEY_0:   cr = {2'd1, 2'd3};
            KEY_3:   cr = {2'd2, 2'd0};
            KEY_6:   cr = {2'd2, 2'd1};
            KEY_9:   cr = {2'd2, 2'd2};
            KEY_EQ:  cr = {2'd2, 2'd3};
            KEY_ADD: cr = {2'd3, 2'd0};
            KEY_SUB: cr = {2'd3, 2'd1};
            KEY_MUL: cr = {2'd3, 2'd2};
            KEY_DIV: cr = {2'd3, 2'd3};
            default: cr = 4'h0;
        endcase
        return cr;
    endfunction

endpackage

// File: rtl/contact_bounce_gen.sv
// rtl/contact_bounce_gen.sv - contact bounce waveform: PULSES pairs of PERIOD-cycle halves, starting at target level
module contact_bounce_gen #(
    parameter int PULSES = 0,
    parameter int PERIOD = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic start,
    input  logic target,
    output logic level_next,
    output logic done
);

    localparam int PER_W  = $clog2(PERIOD) + 1;
    localparam int HALF_W = $clog2(2 * PULSES + 1) + 1;
    localparam logic [PER_W-1:0]  PER_LOAD  = PER_W'(PERIOD - 1);
    localparam logic [HALF_W-1:0] HALF_LOAD = HALF_W'(2 * PULSES - 1);

    logic              active, active_d;
    logic              level, level_d;
    logic [PER_W-1:0]  per_cnt, per_d;
    logic [HALF_W-1:0] half_cnt, half_d;

    assign done       = active && (per_cnt == '0) && (half_cnt == '0);
    // The next level is exported so the owner can register its contact output in step with us.
    assign level_next = level_d;

    always_comb begin
        active_d = active;
        level_d  = level;
        per_d    = per_cnt;
        half_d   = half_cnt;
        if (start) begin
            active_d = 1'b1;
            level_d  = target;
            per_d    = PER_LOAD;
            half_d   = HALF_LOAD;
        end else if (active) begin
            if (per_cnt == '0) begin
                if (half_cnt == '0) begin
                    active_d = 1'b0;
                end else begin
                    half_d  = half_cnt - HALF_W'(1);
                    per_d   = PER_LOAD;
                    level_d = ~level;
                end
            end else begin
                per_d = per_cnt - PER_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            active   <= 1'b0;
            level    <= 1'b0;
            per_cnt  <= '0;
            half_cnt <= '0;
        end else begin
            active   <= active_d;
            level    <= level_d;
            per_cnt  <= per_d;
            half_cnt <= half_d;
        end
    end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// rtl/keypad_matrix_emulator.sv - 4x4 membrane keypad emulator driving active-low ROWS from scanned COLS
module keypad_matrix_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES   = 2_500_000,
    parameter int GAP_CYCLES    = 2_500_000,
    parameter int BOUNCE_PERIOD = 25_000,
    parameter int BOUNCE_PULSES = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] KEY_CODE,
    input  logic       KEY_VALID,
    output logic       KEY_READY,
    input  logic [3:0] COLS,
    output logic [3:0] ROWS,
    output logic       BUSY,
    output logic       CONTACT,
    output logic       KEY_DONE
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam bit BOUNCE_EN = (BOUNCE_PULSES > 0);

    kp_state_t        state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [1:0]       key_col, key_row;
    logic             accept;
    logic             contact_q, contact_d;
    logic [3:0]       rows_q, rows_d;
    logic             gen_start, gen_target, gen_level_next, gen_done;
    logic             key_done;

    contact_bounce_gen #(
        .PULSES (BOUNCE_PULSES),
        .PERIOD (BOUNCE_PERIOD)
    ) u_bounce (
        .CLK        (CLK),
        .RST        (RST),
        .start      (gen_start),
        .target     (gen_target),
        .level_next (gen_level_next),
        .done       (gen_done)
    );

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        accept     = 1'b0;
        gen_start  = 1'b0;
        gen_target = 1'b0;
        key_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (KEY_VALID) begin
                    accept = 1'b1;
                    if (BOUNCE_EN) begin
                        state_d    = ST_PRESS_BOUNCE;
                        gen_start  = 1'b1;
                        gen_target = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end
            end
            ST_PRESS_BOUNCE: begin
                if (gen_done) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    if (BOUNCE_EN) begin
                        state_d    = ST_RELEASE_BOUNCE;
                        gen_start  = 1'b1;
                        gen_target = 1'b0;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            ST_RELEASE_BOUNCE: begin
                if (gen_done) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    key_done = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Contact follows the state being entered so that CONTACT rises the cycle after acceptance.
    always_comb begin
        contact_d = 1'b0;
        if (state_d == ST_HOLD) begin
            contact_d = 1'b1;
        end else if ((state_d == ST_PRESS_BOUNCE) || (state_d == ST_RELEASE_BOUNCE)) begin
            contact_d = gen_level_next;
        end
    end

    always_comb begin
        rows_d = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            rows_d[r] = !(contact_q && (key_row == 2'(r)) && !COLS[key_col]);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            key_col   <= 2'd0;
            key_row   <= 2'd0;
            contact_q <= 1'b0;
            rows_q    <= 4'b1111;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            contact_q <= contact_d;
            rows_q    <= rows_d;
            if (accept) begin
                {key_col, key_row} <= key_to_colrow(KEY_CODE);
            end
        end
    end

    assign KEY_READY = (state == ST_IDLE);
    assign BUSY      = !KEY_READY;
    assign CONTACT   = contact_q;
    assign ROWS      = rows_q;
    assign KEY_DONE  = key_done;

endmodule
